// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cpu_pkg
//  Description : Shared types and constants for the 5-stage core: register
//                address width, the hardwired-zero register index, the hazard
//                controller state encoding and the bundle of pipeline
//                stall/flush controls.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] X0 = 5'd0;

    // Encoding 3 is unused; the controller steers it back to HC_RUN.
    typedef enum logic [1:0] {
        HC_RUN      = 2'd0,
        HC_MEM_WAIT = 2'd1,
        HC_ERROR    = 2'd2
    } hc_state_e;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_stall;
        logic id_ex_flush;
        logic ex_mem_stall;
        logic mem_wb_flush;
    } hazard_ctrl_t;

    // Whole-pipeline freeze: hold every register feeding MEM and drain WB.
    localparam hazard_ctrl_t c_ctrl_freeze = '{
        pc_stall: 1'b1, if_id_stall: 1'b1, if_id_flush: 1'b0,
        id_ex_stall: 1'b1, id_ex_flush: 1'b0, ex_mem_stall: 1'b1,
        mem_wb_flush: 1'b1
    };

    // Squash the two wrong-path instructions behind an EX redirect.
    localparam hazard_ctrl_t c_ctrl_redirect = '{
        pc_stall: 1'b0, if_id_stall: 1'b0, if_id_flush: 1'b1,
        id_ex_stall: 1'b0, id_ex_flush: 1'b1, ex_mem_stall: 1'b0,
        mem_wb_flush: 1'b0
    };

    // Hold the dependent instruction in ID and insert one bubble into EX.
    localparam hazard_ctrl_t c_ctrl_load_use = '{
        pc_stall: 1'b1, if_id_stall: 1'b1, if_id_flush: 1'b0,
        id_ex_stall: 1'b0, id_ex_flush: 1'b1, ex_mem_stall: 1'b0,
        mem_wb_flush: 1'b0
    };

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : W-bit up counter that sticks at all-ones.
//  Ports       : clk   - clock
//                rst_n - asynchronous active-low reset, clears the count
//                inc   - add one this cycle (ignored once saturated)
//                count - current count
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_controller
//  Description : Pipeline sequencer for the 5-stage core. Generates PC and
//                pipeline-register stall/flush controls for load-use
//                hazards, data-memory wait states and EX redirects, keeps
//                saturating stall/flush counters and a sticky memory-timeout
//                error.
//  Ports       : i_clk, i_rst_n           - clock, async active-low reset
//                i_id_rs1/rs2, i_id_uses_* - source operands of ID instruction
//                i_ex_rd, i_ex_mem_read    - destination / load flag in EX
//                i_ex_redirect             - EX redirects the fetch stream
//                i_mem_req, i_mem_ready    - MEM-stage data-memory handshake
//                o_*_stall, o_*_flush      - combinational pipeline controls
//                o_stall_cycles            - registered count of PC stalls
//                o_flush_count             - registered count of redirects
//                o_mem_timeout             - registered sticky error flag
//                o_state                   - FSM state for debug
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_controller
    import cpu_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 256
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    input  logic                  i_id_uses_rs1,
    input  logic                  i_id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] i_ex_rd,
    input  logic                  i_ex_mem_read,
    input  logic                  i_ex_redirect,
    input  logic                  i_mem_req,
    input  logic                  i_mem_ready,
    output logic                  o_pc_stall,
    output logic                  o_if_id_stall,
    output logic                  o_if_id_flush,
    output logic                  o_id_ex_stall,
    output logic                  o_id_ex_flush,
    output logic                  o_ex_mem_stall,
    output logic                  o_mem_wb_flush,
    output logic [CNT_W-1:0]      o_stall_cycles,
    output logic [CNT_W-1:0]      o_flush_count,
    output logic                  o_mem_timeout,
    output logic [1:0]            o_state
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(MEM_TIMEOUT - 1);

    hc_state_e     r_state;
    hc_state_e     w_next_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic          r_timeout;

    logic          w_mem_stall;
    logic          w_load_use;
    logic          w_flush_evt;
    logic          w_stall_inc;
    hazard_ctrl_t  w_ctrl;
    hazard_ctrl_t  w_ctrl_out;

    // Evaluated in every state so the very first not-ready cycle stalls.
    assign w_mem_stall = i_mem_req && !i_mem_ready;

    // Loads into x0 never produce a value, so they cannot create a hazard.
    assign w_load_use = i_ex_mem_read && (i_ex_rd != X0) &&
                        ((i_id_uses_rs1 && (i_ex_rd == i_id_rs1)) ||
                         (i_id_uses_rs2 && (i_ex_rd == i_id_rs2)));

    // ------------------------------------------------------------------
    // Next-state and control priority: ERROR > mem_stall > redirect >
    // load-use. A redirect wins over load-use because the ID instruction
    // is on the wrong path and is being squashed anyway.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_ctrl       = '0;
        w_flush_evt  = 1'b0;

        case (r_state)
            HC_RUN: begin
                if (w_mem_stall) begin
                    w_next_state = HC_MEM_WAIT;
                end
            end
            HC_MEM_WAIT: begin
                if (!w_mem_stall) begin
                    w_next_state = HC_RUN;
                end else if (r_wait_cnt == c_wait_last) begin
                    w_next_state = HC_ERROR;
                end
            end
            HC_ERROR: begin
                w_next_state = HC_ERROR;
            end
            default: begin
                w_next_state = HC_RUN;
            end
        endcase

        if (r_state == HC_ERROR) begin
            w_ctrl = c_ctrl_freeze;
        end else if (w_mem_stall) begin
            w_ctrl = c_ctrl_freeze;
        end else if (i_ex_redirect) begin
            w_ctrl      = c_ctrl_redirect;
            w_flush_evt = 1'b1;
        end else if (w_load_use) begin
            w_ctrl = c_ctrl_load_use;
        end
    end

    // Controls are combinational; force them quiet while reset is held so
    // the pipeline sees no spurious stall before the state settles.
    assign w_ctrl_out = i_rst_n ? w_ctrl : '0;

    assign o_pc_stall     = w_ctrl_out.pc_stall;
    assign o_if_id_stall  = w_ctrl_out.if_id_stall;
    assign o_if_id_flush  = w_ctrl_out.if_id_flush;
    assign o_id_ex_stall  = w_ctrl_out.id_ex_stall;
    assign o_id_ex_flush  = w_ctrl_out.id_ex_flush;
    assign o_ex_mem_stall = w_ctrl_out.ex_mem_stall;
    assign o_mem_wb_flush = w_ctrl_out.mem_wb_flush;

    // ------------------------------------------------------------------
    // State, wait counter and sticky error flag.
    // The wait counter only advances while staying in MEM_WAIT, so it is
    // zero on entry and in RUN.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= HC_RUN;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == HC_MEM_WAIT) && (w_next_state == HC_MEM_WAIT)) begin
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end else begin
                r_wait_cnt <= '0;
            end
            r_timeout <= r_timeout || (w_next_state == HC_ERROR);
        end
    end

    assign o_mem_timeout = r_timeout;
    assign o_state       = r_state;

    // Counters are frozen in ERROR so they describe the run before the fault.
    assign w_stall_inc = w_ctrl.pc_stall && (r_state != HC_ERROR);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .inc   (w_stall_inc),
        .count (o_stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .inc   (w_flush_evt),
        .count (o_flush_count)
    );

endmodule
`default_nettype wire
